fetch_unit: RTL

Instruction fetch stage directly upstream of `control_unit`. It holds the program counter, reads 16-bit instructions from instruction memory through an active-low chip-select/output-enable handshake, and latches each one into an instruction register. It presents `opCode` (instr[15:12]) to `control_unit`, with a valid flag and downstream stall/branch handshakes.

---
 rtl/fetch_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding control_unit.
// Holds the program counter, reads one instruction per fetch from an
// instruction memory with active-low chip-select/output-enable strobes, and
// latches it into an instruction register. Downstream consumes it with
// n_stall=1 and can redirect the next fetch with branch_taken/branch_target.
// A memory that stays not-ready for MAX_WAIT consecutive fetch cycles parks
// the unit in a sticky FAULT state that only reset leaves.

module fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               n_stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic               n_imem_cs,
    output logic               n_imem_oe,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opCode,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               fault
);

    // Wide enough to hold the value MAX_WAIT itself.
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    // Architectural state.
    state_t             state_q;
    logic [ADDR_W-1:0]  fetch_addr_q;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [CNT_W-1:0]   wait_cnt_q;

    // Output flops. The strobes, valid and fault are written alongside the
    // state, so they always equal a decode of the registered state and never
    // glitch the way a combinational decode of two state bits could.
    logic n_cs_q;
    logic n_oe_q;
    logic valid_q;
    logic fault_q;

    // Next-value helpers used by the state machine.
    logic [CNT_W-1:0]  wait_cnt_d;
    logic              timeout_d;
    logic [ADDR_W-1:0] seq_addr_d;
    logic [ADDR_W-1:0] next_addr_d;

    // One more not-ready sample; reaching MAX_WAIT means the memory timed out.
    assign wait_cnt_d = wait_cnt_q + CNT_W'(1);
    assign timeout_d  = (wait_cnt_d == CNT_W'(MAX_WAIT));

    // Sequential successor wraps naturally modulo 2^ADDR_W.
    assign seq_addr_d  = pc_q + ADDR_W'(1);
    assign next_addr_d = branch_taken ? branch_target : seq_addr_d;

    // Control FSM with registered outputs; synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: every assignment to state in this clocked block is
        // non-blocking so that all registers see the pre-edge values of each
        // other; blocking here would make the outcome depend on statement order.
        if (!n_rst) begin
            state_q      <= S_IDLE;
            fetch_addr_q <= RESET_PC;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            wait_cnt_q   <= '0;
            n_cs_q       <= 1'b1;
            n_oe_q       <= 1'b1;
            valid_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    // Start the first fetch; strobes go low with FETCH.
                    state_q    <= S_FETCH;
                    wait_cnt_q <= '0;
                    n_cs_q     <= 1'b0;
                    n_oe_q     <= 1'b0;
                end

                S_FETCH: begin
                    if (imem_ready) begin
                        // Capture wins over a simultaneous timeout.
                        instr_q <= imem_data;
                        pc_q    <= fetch_addr_q;
                        state_q <= S_VALID;
                        valid_q <= 1'b1;
                        n_cs_q  <= 1'b1;
                        n_oe_q  <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                        if (timeout_d) begin
                            state_q <= S_FAULT;
                            fault_q <= 1'b1;
                            n_cs_q  <= 1'b1;
                            n_oe_q  <= 1'b1;
                        end
                    end
                end

                S_VALID: begin
                    // Stalled: hold everything and ignore the branch inputs.
                    if (n_stall) begin
                        fetch_addr_q <= next_addr_d;
                        wait_cnt_q   <= '0;
                        state_q      <= S_FETCH;
                        valid_q      <= 1'b0;
                        n_cs_q       <= 1'b0;
                        n_oe_q       <= 1'b0;
                    end
                end

                S_FAULT: begin
                    // Sticky until reset; instr and pc stay frozen.
                    state_q <= S_FAULT;
                end

                default: begin
                    state_q <= S_IDLE;
                    n_cs_q  <= 1'b1;
                    n_oe_q  <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr   = fetch_addr_q;
    assign n_imem_cs   = n_cs_q;
    assign n_imem_oe   = n_oe_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign fault       = fault_q;

    // opCode is bits [15:12] of the instruction register, so it only moves
    // when instr is captured or reset. Narrower instructions use their top
    // nibble.
    if (INSTR_W >= 16) begin : g_opcode_wide
        assign opCode = instr_q[15:12];
    end else begin : g_opcode_narrow
        assign opCode = instr_q[INSTR_W-1 -: 4];
    end

endmodule
